vga_scan_ctrl: RTL and testbench
================================

VGA_SCAN_CTRL -- requirements
Module: vga_scan_ctrl

Interface
REQ-001 SHALL have port Clk, input, 1 bit: the 25 MHz pixel clock, the single clock of the block.
REQ-002 SHALL have port Rst, input, 1 bit: reset, synchronous to Clk and active-high.
REQ-003 SHALL have port Mode, input, 2 bits: source select (00 blend, 01 left only, 10 right only, 11 treated as 00).
REQ-004 SHALL have port Swap_req, input, 1 bit: level request to flip the double buffer, held high by the requester until Swap_ack.
REQ-005 SHALL have port Mem_l, input, 4 bits: left frame-buffer read data, valid exactly 1 Clk after Addr/Rd_en.
REQ-006 SHALL have port Mem_r, input, 4 bits: right frame-buffer read data, with the same timing as Mem_l.
REQ-007 SHALL have port Addr, output, 18 bits: {Buf_sel, 17-bit pixel index} into the 320x240 buffers.
REQ-008 SHALL have port Rd_en, output, 1 bit: read strobe for both buffers.
REQ-009 SHALL have port Pix_l, output, 4 bits: left nibble to the gray blender.
REQ-010 SHALL have port Pix_r, output, 4 bits: right nibble to the gray blender.
REQ-011 SHALL have port Nblank, output, 1 bit: high during the active video region.
REQ-012 SHALL have port Hsync, output, 1 bit: horizontal sync, active low.
REQ-013 SHALL have port Vsync, output, 1 bit: vertical sync, active low.
REQ-014 SHALL have port Frame_start, output, 1 bit: one-cycle pulse aligned with output pixel (0,0).
REQ-015 SHALL have port Buf_sel, output, 1 bit: currently displayed buffer.
REQ-016 SHALL have port Swap_ack, output, 1 bit: one-cycle acknowledge of a swap request.

Function
REQ-017 SHALL keep hcnt 0..799 and vcnt 0..524; hcnt increments every Clk and wraps to 0 at 799, and vcnt increments on hcnt wrap and wraps to 0 at 524.
REQ-018 SHALL define active as hcnt<640 and vcnt<480; Hsync low for hcnt 656..751; Vsync low for vcnt 490..491.
REQ-019 SHALL register Addr and Rd_en 1 Clk after the counter state: Rd_en=active, and Addr index=(vcnt>>1)*320+(hcnt>>1), giving 2x2 pixel replication.
REQ-020 SHALL hold the Addr index at its last value when Rd_en=0.
REQ-021 SHALL register Pix_l, Pix_r, Nblank, Hsync, Vsync and Frame_start 3 Clk after the counter state, i.e. 2 Clk after Addr, aligned with the Mem data.
REQ-022 SHALL drive Pix_l=Pix_r=0 whenever the delayed active flag is 0.
REQ-023 SHALL select outputs by latched mode: blend gives Pix_l=Mem_l and Pix_r=Mem_r; left gives both=Mem_l; right gives both=Mem_r.
REQ-024 SHALL latch Mode only at the frame boundary (counter transition 799/524 -> 0/0); a Mode change mid-frame takes effect at the next frame.
REQ-025 SHALL, at the frame boundary with Swap_req=1, toggle Buf_sel on that same Clk and pulse Swap_ack for exactly 1 Clk.
REQ-026 SHALL NOT toggle Buf_sel or pulse Swap_ack outside the frame boundary; a pending request waits.
REQ-027 SHALL NOT perform a second swap for a request still high on the cycle after Swap_ack; the next swap is at the next boundary at the earliest.
REQ-028 SHALL use the new Buf_sel as the Addr MSB from the first Addr of the new frame.
REQ-029 SHALL assert Frame_start when the output stage presents pixel (0,0), 3 Clk after counters reach 0/0.

Reset
REQ-030 SHALL, while Rst=1 at a Clk edge, set hcnt=0, vcnt=0, Addr=0, Rd_en=0, Pix_l=Pix_r=0, Nblank=0, Hsync=1, Vsync=1, Frame_start=0, Swap_ack=0, Buf_sel=0 and latched mode=00.
REQ-031 SHALL flush every pipeline stage to the blank/idle value on reset, so that no stale Nblank=1 or sync pulse appears in the 3 Clk after release.
REQ-032 SHALL, on reset mid-frame, abandon the frame and restart at counter 0/0 on the first Clk after Rst falls, with Rd_en=1 one Clk later.
REQ-033 SHALL drop a pending Swap_req at reset; the requester re-asserts it.

Verification
REQ-034 SHALL cover: release Rst -> Rd_en=1 with Addr=0x00000 at cycle 1; Nblank=1 and Frame_start=1 at cycle 3; Nblank falls after exactly 640 cycles.
REQ-035 SHALL cover: free-run -> Hsync low for 96 cycles per 800-cycle line, and Vsync low for 2 lines (1600 cycles) per 420000-cycle frame.
REQ-036 SHALL cover: at counters (3,5) -> Addr index 2*320+1=641; Mem_l=0xA, Mem_r=0x3 with Mode=00 -> Pix_l=0xA, Pix_r=0x3 two cycles later.
REQ-037 SHALL cover: Mode=10 applied mid-frame -> no change this frame; next frame Pix_l=Pix_r=Mem_r.
REQ-038 SHALL cover: Swap_req high at line 100 -> Buf_sel 0->1 and one Swap_ack pulse only at the frame boundary; the first Addr of the next frame = 0x20000.
REQ-039 SHALL cover: Rst pulsed at hcnt=300, vcnt=200 -> outputs at reset values; Nblank=0 for 3 cycles after release, then restart from pixel (0,0).

Source files
------------

// File: rtl/vga_scan_ctrl.sv
// VGA 640x480@60 scan controller: counters, 2x2-replicated frame-buffer fetch,
// double-buffer swap at the frame boundary and a pipeline aligned with read data.
module vga_scan_ctrl #(
    parameter int H_ACTIVE     = 640,
    parameter int H_SYNC_START = 656,
    parameter int H_SYNC_END   = 751,
    parameter int H_TOTAL      = 800,
    parameter int V_ACTIVE     = 480,
    parameter int V_SYNC_START = 490,
    parameter int V_SYNC_END   = 491,
    parameter int V_TOTAL      = 525
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [1:0]  Mode,
    input  logic        Swap_req,
    input  logic [3:0]  Mem_l,
    input  logic [3:0]  Mem_r,
    output logic [17:0] Addr,
    output logic        Rd_en,
    output logic [3:0]  Pix_l,
    output logic [3:0]  Pix_r,
    output logic        Nblank,
    output logic        Hsync,
    output logic        Vsync,
    output logic        Frame_start,
    output logic        Buf_sel,
    output logic        Swap_ack
);

    localparam logic [9:0]  H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0]  H_SS   = 10'(H_SYNC_START);
    localparam logic [9:0]  H_SE   = 10'(H_SYNC_END);
    localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0]  V_SS   = 10'(V_SYNC_START);
    localparam logic [9:0]  V_SE   = 10'(V_SYNC_END);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [16:0] LINE_W = 17'(H_ACTIVE / 2);

    typedef struct packed {
        logic act;
        logic hs_n;
        logic vs_n;
        logic fs;
    } tap_t;

    localparam tap_t TAP_IDLE = '{act: 1'b0, hs_n: 1'b1, vs_n: 1'b1, fs: 1'b0};

    logic [9:0]  hcnt, vcnt;
    logic [1:0]  mode_q;
    logic        h_last, v_last, frame_end, active;
    logic [16:0] idx;
    tap_t        tap_now;
    tap_t        tap_pipe [2:1];
    logic [3:0]  pix_l_d, pix_r_d;

    always_comb begin
        h_last       = (hcnt == H_LAST);
        v_last       = (vcnt == V_LAST);
        frame_end    = h_last && v_last;
        active       = (hcnt < H_ACT) && (vcnt < V_ACT);
        idx          = 17'(vcnt >> 1) * LINE_W + 17'(hcnt >> 1);
        tap_now.act  = active;
        tap_now.hs_n = !((hcnt >= H_SS) && (hcnt <= H_SE));
        tap_now.vs_n = !((vcnt >= V_SS) && (vcnt <= V_SE));
        tap_now.fs   = (hcnt == '0) && (vcnt == '0);
    end

    // Mode and buffer select change only on the edge that wraps the counters to 0/0.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            hcnt     <= '0;
            vcnt     <= '0;
            mode_q   <= 2'b00;
            Buf_sel  <= 1'b0;
            Swap_ack <= 1'b0;
        end else begin
            Swap_ack <= 1'b0;
            if (h_last) begin
                hcnt <= '0;
                vcnt <= v_last ? '0 : vcnt + 10'd1;
            end else begin
                hcnt <= hcnt + 10'd1;
            end
            if (frame_end) begin
                mode_q <= Mode;
                if (Swap_req) begin
                    Buf_sel  <= ~Buf_sel;
                    Swap_ack <= 1'b1;
                end
            end
        end
    end

    // Fetch stage: the buffer bit follows Buf_sel, the pixel index freezes in blanking.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Rd_en <= 1'b0;
            Addr  <= '0;
        end else begin
            Rd_en    <= active;
            Addr[17] <= Buf_sel;
            if (active) Addr[16:0] <= idx;
        end
    end

    always_comb begin
        pix_l_d = 4'h0;
        pix_r_d = 4'h0;
        if (tap_pipe[2].act) begin
            case (mode_q)
                2'b01: begin pix_l_d = Mem_l; pix_r_d = Mem_l; end
                2'b10: begin pix_l_d = Mem_r; pix_r_d = Mem_r; end
                default: begin pix_l_d = Mem_l; pix_r_d = Mem_r; end
            endcase
        end
    end

    // Two tap stages plus the output register line the video flags up with Mem data.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            tap_pipe[1] <= TAP_IDLE;
            tap_pipe[2] <= TAP_IDLE;
            Nblank      <= 1'b0;
            Hsync       <= 1'b1;
            Vsync       <= 1'b1;
            Frame_start <= 1'b0;
            Pix_l       <= 4'h0;
            Pix_r       <= 4'h0;
        end else begin
            tap_pipe[1] <= tap_now;
            tap_pipe[2] <= tap_pipe[1];
            Nblank      <= tap_pipe[2].act;
            Hsync       <= tap_pipe[2].hs_n;
            Vsync       <= tap_pipe[2].vs_n;
            Frame_start <= tap_pipe[2].fs;
            Pix_l       <= pix_l_d;
            Pix_r       <= pix_r_d;
        end
    end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl: full-size instance plus a shrunken-geometry instance so
// frame-level behaviour (swap, mode latch, vsync) is reached in few cycles.
module tb_vga_scan_ctrl;

    logic Clk = 1'b0;
    always #20 Clk = ~Clk;

    logic       Rst = 1'b1;
    logic [1:0] Mode = 2'b00;
    logic       swap_req0 = 1'b0, swap_req1 = 1'b0;
    logic [3:0] Mem_l = 4'h0, Mem_r = 4'h0;

    logic [17:0] addr [2];
    logic        rd_en [2], nblank [2], hsync [2], vsync [2], frame_start [2], buf_sel [2], swap_ack [2];
    logic [3:0]  pix_l [2], pix_r [2];

    vga_scan_ctrl u_big (
        .Clk(Clk), .Rst(Rst), .Mode(Mode), .Swap_req(swap_req0), .Mem_l(Mem_l), .Mem_r(Mem_r),
        .Addr(addr[0]), .Rd_en(rd_en[0]), .Pix_l(pix_l[0]), .Pix_r(pix_r[0]), .Nblank(nblank[0]),
        .Hsync(hsync[0]), .Vsync(vsync[0]), .Frame_start(frame_start[0]), .Buf_sel(buf_sel[0]),
        .Swap_ack(swap_ack[0])
    );

    vga_scan_ctrl #(
        .H_ACTIVE(16), .H_SYNC_START(18), .H_SYNC_END(21), .H_TOTAL(24),
        .V_ACTIVE(8),  .V_SYNC_START(10), .V_SYNC_END(11), .V_TOTAL(13)
    ) u_small (
        .Clk(Clk), .Rst(Rst), .Mode(Mode), .Swap_req(swap_req1), .Mem_l(Mem_l), .Mem_r(Mem_r),
        .Addr(addr[1]), .Rd_en(rd_en[1]), .Pix_l(pix_l[1]), .Pix_r(pix_r[1]), .Nblank(nblank[1]),
        .Hsync(hsync[1]), .Vsync(vsync[1]), .Frame_start(frame_start[1]), .Buf_sel(buf_sel[1]),
        .Swap_ack(swap_ack[1])
    );

    int total = 0, bad = 0;

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int HA [2] = '{640, 16};
    int HSS[2] = '{656, 18};
    int HSE[2] = '{751, 21};
    int HT [2] = '{800, 24};
    int VA [2] = '{480, 8};
    int VSS[2] = '{490, 10};
    int VSE[2] = '{491, 11};
    int VT [2] = '{525, 13};

    function automatic bit in_act(int i, int p);
        return ((p % HT[i]) < HA[i]) && ((p / HT[i]) < VA[i]);
    endfunction

    function automatic int pix_index(int i, int p);
        return ((p / HT[i]) / 2) * (HA[i] / 2) + (p % HT[i]) / 2;
    endfunction

    // Histories indexed by edges ago: [0] is the state after the current edge.
    int  pos_h  [2][4];
    int  mode_h [2][4];
    bit  buf_h  [2][2];
    int  since  [2];
    int  held   [2];
    bit  started = 1'b0;

    always @(posedge Clk) begin
        int np, p, h, v, m;
        bit bnd, req, ack, rd, nb, hs, vs, fs;
        logic [3:0] pl, pr;
        logic [17:0] ea;
        #1;
        if (Rst) started = 1'b1;
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                req = (i == 0) ? swap_req0 : swap_req1;
                for (int k = 3; k > 0; k--) begin
                    pos_h[i][k]  = pos_h[i][k-1];
                    mode_h[i][k] = mode_h[i][k-1];
                end
                buf_h[i][1] = buf_h[i][0];
                ack = 1'b0;
                if (Rst) begin
                    pos_h[i][0] = 0; mode_h[i][0] = 0; buf_h[i][0] = 1'b0;
                    since[i] = 0; held[i] = 0;
                end else begin
                    np  = (pos_h[i][1] + 1) % (HT[i] * VT[i]);
                    bnd = (np == 0);
                    pos_h[i][0]  = np;
                    mode_h[i][0] = bnd ? int'(Mode) : mode_h[i][1];
                    ack          = bnd && req;
                    buf_h[i][0]  = ack ? !buf_h[i][1] : buf_h[i][1];
                    if (since[i] < 3) since[i]++;
                end
                rd = (since[i] >= 1) && in_act(i, pos_h[i][1]);
                if (rd) held[i] = pix_index(i, pos_h[i][1]);
                ea = (since[i] >= 1) ? {buf_h[i][1], 17'(held[i])} : 18'h0;
                nb = 1'b0; hs = 1'b1; vs = 1'b1; fs = 1'b0; pl = 4'h0; pr = 4'h0;
                if (since[i] >= 3) begin
                    p  = pos_h[i][3];
                    h  = p % HT[i];
                    v  = p / HT[i];
                    nb = in_act(i, p);
                    hs = !(h >= HSS[i] && h <= HSE[i]);
                    vs = !(v >= VSS[i] && v <= VSE[i]);
                    fs = (p == 0);
                    m  = mode_h[i][3];
                    if (nb) begin
                        pl = (m == 2) ? Mem_r : Mem_l;
                        pr = (m == 1) ? Mem_l : Mem_r;
                    end
                end
                chk($sformatf("scan%0d", i),
                    40'({addr[i], rd_en[i], pix_l[i], pix_r[i], nblank[i], hsync[i], vsync[i],
                         frame_start[i], buf_sel[i], swap_ack[i]}),
                    40'({ea, rd, pl, pr, nb, hs, vs, fs, buf_h[i][0], ack}));
            end
        end
    end

    // ---------------- directed vectors for the full-size instance ----------------
    typedef struct {
        int          cyc;
        logic [3:0]  ml, mr;
        logic        rd;
        logic [17:0] addr;
        logic        nb, hs, fs;
        logic [3:0]  pl, pr;
    } vec_t;

    vec_t tab [15];

    task automatic wait_fs(input int i, input int lim, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < lim && !ok; k++) begin
            @(negedge Clk);
            @(posedge Clk); #1;
            if (frame_start[i]) ok = 1'b1;
        end
    endtask

    initial begin
        int c, acks, after, hs_big, hs_small, vs_small, rst_cnt;
        bit ok;
        logic [17:0] addr_after;

        tab[0]  = '{1,    4'h0, 4'h0, 1'b1, 18'd0,   1'b0, 1'b1, 1'b0, 4'h0, 4'h0};
        tab[1]  = '{3,    4'h0, 4'h0, 1'b1, 18'd1,   1'b1, 1'b1, 1'b1, 4'h0, 4'h0};
        tab[2]  = '{4,    4'h0, 4'h0, 1'b1, 18'd1,   1'b1, 1'b1, 1'b0, 4'h0, 4'h0};
        tab[3]  = '{640,  4'h0, 4'h0, 1'b1, 18'd319, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0};
        tab[4]  = '{641,  4'h0, 4'h0, 1'b0, 18'd319, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0};
        tab[5]  = '{642,  4'h0, 4'h0, 1'b0, 18'd319, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0};
        tab[6]  = '{643,  4'h0, 4'h0, 1'b0, 18'd319, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0};
        tab[7]  = '{658,  4'h0, 4'h0, 1'b0, 18'd319, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0};
        tab[8]  = '{659,  4'h0, 4'h0, 1'b0, 18'd319, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0};
        tab[9]  = '{754,  4'h0, 4'h0, 1'b0, 18'd319, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0};
        tab[10] = '{755,  4'h0, 4'h0, 1'b0, 18'd319, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0};
        tab[11] = '{801,  4'h0, 4'h0, 1'b1, 18'd0,   1'b0, 1'b1, 1'b0, 4'h0, 4'h0};
        tab[12] = '{1601, 4'h0, 4'h0, 1'b1, 18'd320, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0};
        tab[13] = '{4004, 4'h0, 4'h0, 1'b1, 18'd641, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0};
        tab[14] = '{4006, 4'hA, 4'h3, 1'b1, 18'd642, 1'b1, 1'b1, 1'b0, 4'hA, 4'h3};

        Rst = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk) Rst = 1'b0;
        c = 0;
        for (int e = 0; e < 15; e++) begin
            while (c < tab[e].cyc) begin
                if (c > 0) @(negedge Clk);
                Mem_l = (c + 1 == tab[e].cyc) ? tab[e].ml : 4'h0;
                Mem_r = (c + 1 == tab[e].cyc) ? tab[e].mr : 4'h0;
                @(posedge Clk); #1;
                c++;
            end
            chk($sformatf("vec_cyc%0d", tab[e].cyc),
                40'({rd_en[0], addr[0], nblank[0], hsync[0], frame_start[0], pix_l[0], pix_r[0]}),
                40'({tab[e].rd, tab[e].addr, tab[e].nb, tab[e].hs, tab[e].fs, tab[e].pl, tab[e].pr}));
        end

        // Sync pulse widths over steady-state windows.
        hs_big = 0; hs_small = 0; vs_small = 0;
        for (int k = 0; k < 800; k++) begin
            @(negedge Clk);
            Mem_l = 4'($urandom); Mem_r = 4'($urandom);
            @(posedge Clk); #1;
            if (!hsync[0]) hs_big++;
            if (k < 24 && !hsync[1]) hs_small++;
            if (k < 312 && !vsync[1]) vs_small++;
        end
        chk("hsync_low_big", 40'(hs_big), 40'd96);
        chk("hsync_low_small", 40'(hs_small), 40'd4);
        chk("vsync_low_small", 40'(vs_small), 40'd48);

        // Swap request mid-frame on the small instance, kept high one extra edge after ack.
        @(negedge Clk) swap_req1 = 1'b1;
        acks = 0; after = -1; addr_after = '0;
        for (int k = 0; k < 700 && after < 4; k++) begin
            @(negedge Clk);
            if (after >= 1) swap_req1 = 1'b0;
            @(posedge Clk); #1;
            if (swap_ack[1]) begin acks++; if (after < 0) after = 0; end
            else if (after >= 0) after++;
            if (after == 1) addr_after = addr[1];
        end
        chk("swap_ack_count", 40'(acks), 40'd1);
        chk("swap_buf_sel", 40'(buf_sel[1]), 40'd1);
        chk("swap_first_addr", 40'(addr_after), 40'h20000);

        // Mode change mid-frame applies from the next frame only.
        wait_fs(1, 400, ok);
        chk("mode_fs_seen", 40'(ok), 40'd1);
        repeat (50) begin @(negedge Clk); @(posedge Clk); end
        @(negedge Clk);
        Mode = 2'b10; Mem_l = 4'h5; Mem_r = 4'h9;
        ok = 1'b0;
        for (int k = 0; k < 30 && !ok; k++) begin
            @(posedge Clk); #1;
            if (nblank[1]) ok = 1'b1;
            else @(negedge Clk);
        end
        chk("mode_same_frame", 40'({ok, pix_l[1], pix_r[1]}), 40'({1'b1, 4'h5, 4'h9}));
        wait_fs(1, 400, ok);
        chk("mode_next_frame", 40'({ok, pix_l[1], pix_r[1]}), 40'({1'b1, 4'h9, 4'h9}));

        // Reset mid-frame inside a big-instance sync pulse, with a swap request pending.
        ok = 1'b0;
        for (int k = 0; k < 1000 && !ok; k++) begin
            @(negedge Clk); @(posedge Clk); #1;
            if (!hsync[0]) ok = 1'b1;
        end
        chk("rst_hsync_seen", 40'(ok), 40'd1);
        @(negedge Clk);
        Rst = 1'b1; swap_req1 = 1'b1;
        @(posedge Clk); #1;
        for (int i = 0; i < 2; i++)
            chk($sformatf("rst_vals%0d", i),
                40'({addr[i], rd_en[i], pix_l[i], pix_r[i], nblank[i], hsync[i], vsync[i],
                     frame_start[i], buf_sel[i], swap_ack[i]}),
                40'({18'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
        @(negedge Clk);
        Rst = 1'b0; swap_req1 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) @(negedge Clk);
            @(posedge Clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (k == 1)
                    chk($sformatf("rel1_%0d", i), 40'({nblank[i], hsync[i], rd_en[i], addr[i]}),
                        40'({1'b0, 1'b1, 1'b1, 18'h0}));
                else if (k == 2)
                    chk($sformatf("rel2_%0d", i), 40'({nblank[i], hsync[i], vsync[i]}), 40'({1'b0, 1'b1, 1'b1}));
                else
                    chk($sformatf("rel3_%0d", i), 40'({nblank[i], frame_start[i]}), 40'({1'b1, 1'b1}));
            end
        end

        // Random traffic; the always-on model does the checking.
        rst_cnt = 0;
        for (int k = 0; k < 20000; k++) begin
            @(negedge Clk);
            Mem_l = 4'($urandom); Mem_r = 4'($urandom);
            if ($urandom_range(0, 399) == 0) Mode = 2'($urandom);
            if (swap_ack[0]) swap_req0 = 1'b0;
            else if (!swap_req0 && $urandom_range(0, 299) == 0) swap_req0 = 1'b1;
            if (swap_ack[1]) swap_req1 = 1'b0;
            else if (!swap_req1 && $urandom_range(0, 99) == 0) swap_req1 = 1'b1;
            if (rst_cnt > 0) begin rst_cnt--; Rst = 1'b1; end
            else if ($urandom_range(0, 2499) == 0) begin rst_cnt = $urandom_range(0, 2); Rst = 1'b1; end
            else Rst = 1'b0;
        end
        @(negedge Clk) Rst = 1'b0;
        repeat (4) @(posedge Clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
